// File: rtl/ir_seq_pkg.sv
// Shared types and ROM-format constants for the TV-B-Gone code sequencer.
package ir_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD_DIV,
        RD_CNT,
        RD_ON,
        MARK,
        RD_OFF,
        SPACE,
        GAP,
        DONE
    } seq_state_t;

    // Word offsets within a code header
    localparam int HDR_DIV = 0;
    localparam int HDR_CNT = 1;

    localparam logic [15:0] END_MARKER = 16'h0000;

endpackage

// File: rtl/ir_tick_timer.sv
// Tick prescaler plus 16-bit tick down-counter; expired is high in the last
// clock of a loaded duration so the caller can leave its state on that edge.
module ir_tick_timer #(
    parameter int TICK_DIV = 80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [15:0] load_ticks,
    output logic        expired
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre;
    logic [15:0]   remain;
    logic          running;
    logic          tick_end;

    assign tick_end = running && (pre == PRE_LAST);
    assign expired  = tick_end && (remain == 16'd1);

    // A load restarts the prescaler so every duration is an exact tick multiple
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pre     <= '0;
            remain  <= '0;
            running <= 1'b0;
        end else if (load) begin
            pre     <= '0;
            remain  <= load_ticks;
            running <= (load_ticks != 16'd0);
        end else if (running) begin
            if (tick_end) begin
                pre    <= '0;
                remain <= remain - 16'd1;
                if (remain == 16'd1) begin
                    running <= 1'b0;
                end
            end else begin
                pre <= pre + PW'(1);
            end
        end
    end

endmodule

// File: rtl/ir_code_sequencer.sv
// Walks the EU code ROM, loading each carrier divider and gating the carrier
// with the code's mark/space pairs, with a fixed gap between codes.
module ir_code_sequencer
    import ir_seq_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int TICK_DIV  = 80,
    parameter int GAP_TICKS = 20000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [15:0]       carrier_div,
    output logic              ir_en,
    output logic              busy,
    output logic              done,
    output logic [7:0]        code_idx
);

    seq_state_t        state, state_n;
    logic              rd_phase, rd_phase_n;
    logic [ADDR_W-1:0] rom_addr_n;
    logic [15:0]       carrier_div_n;
    logic              ir_en_n, busy_n, done_n;
    logic [7:0]        code_idx_n;
    logic [7:0]        pair_cnt, pair_cnt_n;
    logic              tmr_load, tmr_clear, tmr_expired;
    logic [15:0]       tmr_ticks;
    logic              pair_end, gap_enter, gap_over;

    ir_tick_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (tmr_clear),
        .load      (tmr_load),
        .load_ticks(tmr_ticks),
        .expired   (tmr_expired)
    );

    assign gap_over = tmr_expired || (GAP_TICKS == 0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rd_phase    <= 1'b0;
            rom_addr    <= '0;
            carrier_div <= '0;
            ir_en       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            code_idx    <= '0;
            pair_cnt    <= '0;
        end else begin
            state       <= state_n;
            rd_phase    <= rd_phase_n;
            rom_addr    <= rom_addr_n;
            carrier_div <= carrier_div_n;
            ir_en       <= ir_en_n;
            busy        <= busy_n;
            done        <= done_n;
            code_idx    <= code_idx_n;
            pair_cnt    <= pair_cnt_n;
        end
    end

    // Each RD_* state spends phase 0 presenting rom_addr and phase 1 capturing
    // rom_data; the address advances on the capture edge.
    always_comb begin
        state_n       = state;
        rd_phase_n    = 1'b0;
        rom_addr_n    = rom_addr;
        carrier_div_n = carrier_div;
        ir_en_n       = ir_en;
        busy_n        = busy;
        done_n        = 1'b0;
        code_idx_n    = code_idx;
        pair_cnt_n    = pair_cnt;
        tmr_load      = 1'b0;
        tmr_clear     = 1'b0;
        tmr_ticks     = rom_data;
        pair_end      = 1'b0;
        gap_enter     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n    = RD_DIV;
                    rom_addr_n = '0;
                    code_idx_n = '0;
                    busy_n     = 1'b1;
                end
            end
            RD_DIV: begin
                if (!rd_phase) begin
                    rd_phase_n = 1'b1;
                end else begin
                    rom_addr_n = rom_addr + ADDR_W'(1);
                    if (rom_data == END_MARKER) begin
                        state_n       = DONE;
                        done_n        = 1'b1;
                        busy_n        = 1'b0;
                        carrier_div_n = '0;
                    end else begin
                        carrier_div_n = rom_data;
                        state_n       = RD_CNT;
                    end
                end
            end
            RD_CNT: begin
                if (!rd_phase) begin
                    rd_phase_n = 1'b1;
                end else begin
                    rom_addr_n = rom_addr + ADDR_W'(1);
                    pair_cnt_n = rom_data[7:0];
                    if (rom_data[7:0] == 8'd0) gap_enter = 1'b1;
                    else                       state_n   = RD_ON;
                end
            end
            RD_ON: begin
                if (!rd_phase) begin
                    rd_phase_n = 1'b1;
                end else begin
                    rom_addr_n = rom_addr + ADDR_W'(1);
                    if (rom_data != 16'd0) begin
                        state_n  = MARK;
                        ir_en_n  = 1'b1;
                        tmr_load = 1'b1;
                    end else begin
                        state_n = RD_OFF;
                    end
                end
            end
            MARK: begin
                if (tmr_expired) begin
                    ir_en_n = 1'b0;
                    state_n = RD_OFF;
                end
            end
            RD_OFF: begin
                if (!rd_phase) begin
                    rd_phase_n = 1'b1;
                end else begin
                    rom_addr_n = rom_addr + ADDR_W'(1);
                    if (rom_data != 16'd0) begin
                        state_n  = SPACE;
                        tmr_load = 1'b1;
                    end else begin
                        pair_end = 1'b1;
                    end
                end
            end
            SPACE: begin
                if (tmr_expired) pair_end = 1'b1;
            end
            GAP: begin
                if (gap_over) begin
                    code_idx_n = code_idx + 8'd1;
                    state_n    = RD_DIV;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (pair_end) begin
            pair_cnt_n = pair_cnt - 8'd1;
            if (pair_cnt == 8'd1) gap_enter = 1'b1;
            else                  state_n   = RD_ON;
        end

        if (gap_enter) begin
            state_n   = GAP;
            tmr_load  = 1'b1;
            tmr_ticks = 16'(GAP_TICKS);
        end

        // Abort wins over everything, including a start seen in IDLE
        if (abort) begin
            state_n       = IDLE;
            rd_phase_n    = 1'b0;
            rom_addr_n    = rom_addr;
            carrier_div_n = carrier_div;
            ir_en_n       = 1'b0;
            busy_n        = 1'b0;
            done_n        = 1'b0;
            code_idx_n    = code_idx;
            pair_cnt_n    = pair_cnt;
            tmr_load      = 1'b0;
            tmr_clear     = 1'b1;
        end
    end

endmodule

// File: tb/tb_ir_code_sequencer.sv
// Directed bench for ir_code_sequencer: a table-walking model predicts every
// cycle of output after start, and one negedge process compares the DUT to it.
module tb_ir_code_sequencer;

    localparam int ADDR_W = 10;
    localparam int TDIV   = 4;
    localparam int GAPT   = 3;
    localparam int ROM_SZ = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst, start, abort;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic [15:0]       carrier_div;
    logic              ir_en, busy, done;
    logic [7:0]        code_idx;

    always #5 clk = ~clk;

    logic [15:0] rom_mem [0:ROM_SZ-1];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    ir_code_sequencer #(.ADDR_W(ADDR_W), .TICK_DIV(TDIV), .GAP_TICKS(GAPT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .carrier_div(carrier_div),
        .ir_en      (ir_en),
        .busy       (busy),
        .done       (done),
        .code_idx   (code_idx)
    );

    typedef struct packed {
        logic        ir_en;
        logic        busy;
        logic        done;
        logic [15:0] carrier_div;
        logic [7:0]  code_idx;
    } obs_t;

    obs_t exp_q[$];
    obs_t idle_exp;
    obs_t act, want;
    bit   check_en = 1'b0;
    int   checks = 0;
    int   fails = 0;
    int   cur_cyc = 0;
    int   sim_cyc = 0;
    int   len;
    obs_t f;

    function automatic obs_t mk(input logic ir, input logic bz, input logic dn,
                                input logic [15:0] dv, input logic [7:0] ix);
        obs_t o;
        o.ir_en = ir; o.busy = bz; o.done = dn; o.carrier_div = dv; o.code_idx = ix;
        return o;
    endfunction

    task automatic push_n(input int cnt, input obs_t o);
        for (int i = 0; i < cnt; i++) exp_q.push_back(o);
    endtask

    // Cycle-by-cycle expectation straight from the table format: every read
    // costs two clocks, marks/spaces/gap cost ticks*TDIV clocks, zero lengths vanish.
    task automatic build_trace(output int n_cyc);
        logic [15:0] dv, w;
        int a, k, n;
        dv = idle_exp.carrier_div;
        a = 0;
        k = 0;
        for (int guard = 0; guard < 256; guard++) begin
            push_n(2, mk(1'b0, 1'b1, 1'b0, dv, 8'(k)));
            w = rom_mem[a]; a = (a + 1) % ROM_SZ;
            if (w == 16'h0000) begin
                push_n(1, mk(1'b0, 1'b0, 1'b1, 16'h0000, 8'(k)));
                idle_exp = mk(1'b0, 1'b0, 1'b0, 16'h0000, 8'(k));
                break;
            end
            dv = w;
            w = rom_mem[a]; a = (a + 1) % ROM_SZ;
            n = int'(w[7:0]);
            push_n(2, mk(1'b0, 1'b1, 1'b0, dv, 8'(k)));
            for (int p = 0; p < n; p++) begin
                push_n(2, mk(1'b0, 1'b1, 1'b0, dv, 8'(k)));
                w = rom_mem[a]; a = (a + 1) % ROM_SZ;
                push_n(int'(w) * TDIV, mk(1'b1, 1'b1, 1'b0, dv, 8'(k)));
                push_n(2, mk(1'b0, 1'b1, 1'b0, dv, 8'(k)));
                w = rom_mem[a]; a = (a + 1) % ROM_SZ;
                push_n(int'(w) * TDIV, mk(1'b0, 1'b1, 1'b0, dv, 8'(k)));
            end
            push_n(GAPT * TDIV, mk(1'b0, 1'b1, 1'b0, dv, 8'(k)));
            k = (k + 1) % 256;
        end
        n_cyc = exp_q.size();
    endtask

    always @(negedge clk) begin
        sim_cyc <= sim_cyc + 1;
        if (check_en) begin
            act = mk(ir_en, busy, done, carrier_div, code_idx);
            if (exp_q.size() > 0) want = exp_q.pop_front();
            else                  want = idle_exp;
            checks++;
            if (act !== want) begin
                fails++;
                $display("[TB] FAIL trace t%0d: got ir_en=%b busy=%b done=%b div=%h idx=%0d, want ir_en=%b busy=%b done=%b div=%h idx=%0d",
                         sim_cyc, act.ir_en, act.busy, act.done, act.carrier_div, act.code_idx,
                         want.ir_en, want.busy, want.done, want.carrier_div, want.code_idx);
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < ROM_SZ; i++) rom_mem[i] = 16'h0000;
    endtask

    task automatic load_test1();
        clear_rom();
        rom_mem[0] = 16'h0034; rom_mem[1] = 16'd2;
        rom_mem[2] = 16'd5;    rom_mem[3] = 16'd3;
        rom_mem[4] = 16'd1;    rom_mem[5] = 16'd0;
        rom_mem[6] = 16'h0000;
    endtask

    // Pulse start for one cycle and queue the predicted trace; afterwards the
    // bench sits in cycle 1 (first cycle after start was sampled).
    task automatic applyStimulus(output int n_cyc);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        build_trace(n_cyc);
        cur_cyc = 1;
    endtask

    task automatic goto_cycle(input int c);
        repeat (c - cur_cyc) @(posedge clk);
        #1;
        cur_cyc = c;
    endtask

    task automatic check_at(input int c, input string name, input int expected, input int sel);
        goto_cycle(c);
        @(negedge clk);
        case (sel)
            0: checkOutput(name, int'(ir_en), expected);
            1: checkOutput(name, int'(busy), expected);
            2: checkOutput(name, int'(done), expected);
            3: checkOutput(name, int'(carrier_div), expected);
            4: checkOutput(name, int'(code_idx), expected);
            default: checkOutput(name, int'(rom_addr), expected);
        endcase
    endtask

    // Cut the prediction after the current cycle; from then on expect idle.
    task automatic truncate_here(input bit to_reset);
        f = exp_q[0];
        exp_q.delete();
        exp_q.push_back(f);
        if (to_reset) idle_exp = mk(1'b0, 1'b0, 1'b0, 16'h0000, 8'd0);
        else          idle_exp = mk(1'b0, 1'b0, 1'b0, f.carrier_div, f.code_idx);
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() > 0 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL drain: %0d predicted cycles left, want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        clear_rom();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle_exp = mk(1'b0, 1'b0, 1'b0, 16'h0000, 8'd0);
        check_en = 1'b1;
        @(negedge clk);
        checkOutput("reset rom_addr", int'(rom_addr), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset carrier_div", int'(carrier_div), 0);
        checkOutput("reset ir_en", int'(ir_en), 0);

        // Single code with a start pulse while busy at cycle 30
        load_test1();
        applyStimulus(len);
        checkOutput("t1 trace length", len, 63);
        check_at(3,  "t1 div loaded", 16'h0034, 3);
        check_at(7,  "t1 mark1 first", 1, 0);
        check_at(26, "t1 mark1 last", 1, 0);
        check_at(27, "t1 mark1 off", 0, 0);
        goto_cycle(30);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cur_cyc = 31;
        check_at(43, "t1 mark2 first", 1, 0);
        check_at(47, "t1 mark2 off", 0, 0);
        check_at(63, "t1 done", 1, 2);
        check_at(63, "t1 busy at done", 0, 1);
        wait_drain();

        // Empty table
        clear_rom();
        applyStimulus(len);
        checkOutput("t2 trace length", len, 3);
        check_at(3, "t2 done", 1, 2);
        check_at(3, "t2 carrier_div", 0, 3);
        wait_drain();

        // Two codes, second has no pairs
        clear_rom();
        rom_mem[0] = 16'h0034; rom_mem[1] = 16'd1;
        rom_mem[2] = 16'd2;    rom_mem[3] = 16'd2;
        rom_mem[4] = 16'h0051; rom_mem[5] = 16'h0300;
        rom_mem[6] = 16'h0000;
        applyStimulus(len);
        checkOutput("t3 trace length", len, 55);
        check_at(36, "t3 idx before step", 0, 4);
        check_at(37, "t3 idx after step", 1, 4);
        check_at(39, "t3 second div", 16'h0051, 3);
        check_at(55, "t3 done", 1, 2);
        wait_drain();

        // Abort on the 10th cycle of the first mark, then replay
        load_test1();
        applyStimulus(len);
        goto_cycle(16);
        truncate_here(1'b0);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        cur_cyc = 17;
        check_at(17, "t4 ir_en after abort", 0, 0);
        check_at(17, "t4 busy after abort", 0, 1);
        check_at(17, "t4 div held", 16'h0034, 3);
        wait_drain();
        applyStimulus(len);
        check_at(1, "t4 replay addr", 0, 5);
        wait_drain();

        // start and abort together from IDLE do nothing
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("t5 busy stays low", int'(busy), 0);

        // Zero-length mark, then reset in the middle of the space
        clear_rom();
        rom_mem[0] = 16'h0022; rom_mem[1] = 16'd1;
        rom_mem[2] = 16'd0;    rom_mem[3] = 16'd4;
        rom_mem[4] = 16'h0000;
        applyStimulus(len);
        checkOutput("t6 trace length", len, 39);
        check_at(7, "t6 no mark", 0, 0);
        wait_drain();
        applyStimulus(len);
        goto_cycle(12);
        truncate_here(1'b1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        cur_cyc = 13;
        check_at(13, "t6 rom_addr after rst", 0, 5);
        check_at(13, "t6 div after rst", 0, 3);
        wait_drain();

        check_en = 1'b0;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
